// File: rtl/match_controller.sv
// Match sequencer: TITLE -> COUNTDOWN -> PLAY -> KO_PAUSE/GAME_OVER -> TITLE, timers advance on frame_tick.
// Latency: every output is registered; a state change shows one clk after the input that causes it.
// Optional pause: define MATCH_PAUSE_EN to let a start edge in PLAY toggle a PAUSED state (encoding 5).
module match_controller #(
    parameter int FRAMES_PER_SEC       = 60,
    parameter int COUNT_FROM           = 3,
    parameter int KO_PAUSE_FRAMES      = 90,
    parameter int GAMEOVER_LOCK_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start1,
    input  logic       start2,
    input  logic [1:0] stocks1,
    input  logic [1:0] stocks2,
    input  logic       respawn1,
    input  logic       respawn2,
    output logic [2:0] match_state,
    output logic       game_active,
    output logic       match_reset,
    output logic [1:0] countdown_digit,
    output logic [1:0] winner
);

    // One shared frame counter, sized for the longest timer; loads are param-1, never wraps.
    localparam int MAX_AB = (FRAMES_PER_SEC > KO_PAUSE_FRAMES) ? FRAMES_PER_SEC : KO_PAUSE_FRAMES;
    localparam int MAX_F  = (MAX_AB > GAMEOVER_LOCK_FRAMES) ? MAX_AB : GAMEOVER_LOCK_FRAMES;
    localparam int CW     = (MAX_F > 1) ? $clog2(MAX_F) : 1;

    localparam logic [CW-1:0] LD_SEC = CW'(FRAMES_PER_SEC - 1);
    localparam logic [CW-1:0] LD_KO  = CW'(KO_PAUSE_FRAMES - 1);
    localparam logic [CW-1:0] LD_GO  = CW'(GAMEOVER_LOCK_FRAMES - 1);
    localparam logic [1:0]    DIGIT0 = 2'(COUNT_FROM);

    typedef enum logic [2:0] {
        S_TITLE     = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_KO_PAUSE  = 3'd3,
        S_GAME_OVER = 3'd4,
        S_PAUSED    = 3'd5
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    digit_n, winner_n;
    logic          mreset_n;
    logic          start_any, start_any_q, start_edge;
    logic          stock_loss;
    logic [1:0]    loss_winner;

    // Held start levels never re-trigger: only the rising edge of either button counts.
    assign start_any   = start1 | start2;
    assign start_edge  = start_any & ~start_any_q;
    assign match_state = state;

    // Outcome of a stock check: draw beats either single loss.
    assign stock_loss  = (stocks1 == 2'd0) || (stocks2 == 2'd0);
    assign loss_winner = ((stocks1 == 2'd0) && (stocks2 == 2'd0)) ? 2'd3 :
                         (stocks1 == 2'd0)                        ? 2'd2 : 2'd1;

    // State register plus all registered outputs; reset never emits match_reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_TITLE;
            cnt             <= '0;
            countdown_digit <= 2'd0;
            winner          <= 2'd0;
            match_reset     <= 1'b0;
            game_active     <= 1'b0;
            start_any_q     <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            countdown_digit <= digit_n;
            winner          <= winner_n;
            match_reset     <= mreset_n;
            game_active     <= (state_n == S_PLAY);
            start_any_q     <= start_any;
        end
    end

    // Next-state and next-output logic; a counter load on state entry overrides any coincident tick.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        digit_n  = countdown_digit;
        winner_n = winner;
        mreset_n = 1'b0;
        case (state)
            S_TITLE: begin
                if (start_edge) begin
                    state_n  = S_COUNTDOWN;
                    mreset_n = 1'b1;
                    digit_n  = DIGIT0;
                    cnt_n    = LD_SEC;
                end
            end
            S_COUNTDOWN: begin
                if (frame_tick) begin
                    if (cnt == '0) begin
                        if (countdown_digit == 2'd1) begin
                            state_n = S_PLAY;
                            digit_n = 2'd0;
                        end else begin
                            digit_n = countdown_digit - 2'd1;
                            cnt_n   = LD_SEC;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (stock_loss) begin
                    state_n  = S_GAME_OVER;
                    winner_n = loss_winner;
                    cnt_n    = LD_GO;
`ifdef MATCH_PAUSE_EN
                end else if (start_edge) begin
                    state_n = S_PAUSED;
`endif
                end else if (respawn1 | respawn2) begin
                    state_n = S_KO_PAUSE;
                    cnt_n   = LD_KO;
                end
            end
            S_KO_PAUSE: begin
                // Stock decrement can trail the respawn pulse, so keep checking here.
                if (stock_loss) begin
                    state_n  = S_GAME_OVER;
                    winner_n = loss_winner;
                    cnt_n    = LD_GO;
                end else if (frame_tick) begin
                    if (cnt == '0) state_n = S_PLAY;
                    else           cnt_n   = cnt - 1'b1;
                end
            end
            S_GAME_OVER: begin
                if (start_edge && (cnt == '0)) begin
                    state_n  = S_TITLE;
                    winner_n = 2'd0;
                end else if (frame_tick && (cnt != '0)) begin
                    cnt_n = cnt - 1'b1;
                end
            end
`ifdef MATCH_PAUSE_EN
            S_PAUSED: begin
                if (start_edge) state_n = S_PLAY;
            end
`endif
            default: state_n = S_TITLE;
        endcase
    end

endmodule
